// File: rtl/sik_pkg.sv
// sik_pkg: shared word type and read-response port tags for the SIK memory side
package sik_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] WORD;
  typedef enum logic {TAG_I, TAG_D} tag_e;
endpackage

// File: rtl/sik_read_pipe.sv
// sik_read_pipe: LAT-stage valid/tag/data delay line that steers read data to the fetch or data port
// Ports: clk, rst_n (async active-low clear), valid_i/rtag_i/data_i (read launched on this edge),
//   i_valid_o/i_data_o and d_valid_o/d_data_o (per-port response, data holds when not valid),
//   busy_o (any read still in flight).
module sik_read_pipe
  import sik_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  input  tag_e rtag_i,
  input  WORD  data_i,
  output logic i_valid_o,
  output WORD  i_data_o,
  output logic d_valid_o,
  output WORD  d_data_o,
  output logic busy_o
);
  logic [LAT-1:0] v_q, v_n;
  tag_e t_q [LAT];
  tag_e t_n [LAT];
  WORD d_q [LAT];
  WORD d_n [LAT];
  WORD i_hold_q, d_hold_q;
  for (genvar s = 0; s < LAT; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign v_n[s] = valid_i;
      assign t_n[s] = rtag_i;
      assign d_n[s] = data_i;
    end else begin : g_tail
      assign v_n[s] = v_q[s-1];
      assign t_n[s] = t_q[s-1];
      assign d_n[s] = d_q[s-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= '0;
      t_q      <= '{default: TAG_I};
      d_q      <= '{default: '0};
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      v_q      <= v_n;
      t_q      <= t_n;
      d_q      <= d_n;
      i_hold_q <= i_data_o;
      d_hold_q <= d_data_o;
    end
  end
  // hold registers remember the last delivered word so rdata is stable between pulses
  assign i_valid_o = v_q[LAT-1] && t_q[LAT-1] == TAG_I;
  assign d_valid_o = v_q[LAT-1] && t_q[LAT-1] == TAG_D;
  assign i_data_o  = i_valid_o ? d_q[LAT-1] : i_hold_q;
  assign d_data_o  = d_valid_o ? d_q[LAT-1] : d_hold_q;
  assign busy_o    = |v_q;
endmodule

// File: rtl/sik_mem_responder.sv
// sik_mem_responder: single-ported main memory answering fetch and load/store initiators
// Ports: clk, reset (async active-low); fetch port i_req/i_addr -> i_gnt/i_rvalid/i_rdata;
//   data port d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata; busy = read in flight.
module sik_mem_responder
  import sik_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LAT    = 2,
  parameter int STARVE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output WORD               i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  WORD               d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output WORD               d_rdata,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;
  WORD mem_q [DEPTH];
  logic [1:0] starve_q, starve_d;
  logic rd_valid;
  tag_e rd_tag;
  WORD rd_data;
  // data has priority until fetch has been denied STARVE cycles in a row
  assign i_gnt = reset && i_req && (!d_req || int'(starve_q) == STARVE);
  assign d_gnt = reset && d_req && !i_gnt;
  assign starve_d = (i_req && !i_gnt) ? (starve_q == 2'd3 ? 2'd3 : starve_q + 2'd1) : 2'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= 2'd0;
    else starve_q <= starve_d;
  end
  always_ff @(posedge clk) begin
    if (d_gnt && d_we) mem_q[d_addr] <= d_wdata;
  end
  assign rd_valid = i_gnt || (d_gnt && !d_we);
  assign rd_tag   = i_gnt ? TAG_I : TAG_D;
  assign rd_data  = mem_q[i_gnt ? i_addr : d_addr];
  sik_read_pipe #(.LAT(LAT)) u_pipe (
    .clk      (clk),
    .rst_n    (reset),
    .valid_i  (rd_valid),
    .rtag_i   (rd_tag),
    .data_i   (rd_data),
    .i_valid_o(i_rvalid),
    .i_data_o (i_rdata),
    .d_valid_o(d_rvalid),
    .d_data_o (d_rdata),
    .busy_o   (busy)
  );
endmodule

// File: tb/tb_sik_mem_responder.sv
// tb_sik_mem_responder: four responders (LAT 2/1/3/4, one with 8-bit addresses) driven in lockstep against a reference model
module tb_sik_mem_responder;
  logic clk = 0, reset = 1, i_req = 0, d_req = 0, d_we = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0] gi, gd, iv, dv, bs;
  logic [15:0] ir [4];
  logic [15:0] dr [4];
  int lat_t [4] = '{2, 1, 3, 4};
  int vec = 0, err = 0, cnt = 0;
  logic last_gi;
  typedef struct {bit v; bit is_i; logic [15:0] d16; logic [15:0] d8;} ent_t;
  ent_t hist [$];
  logic [15:0] m16 [logic [15:0]];
  logic [15:0] m8 [256];
  logic [15:0] exp_ir [4];
  logic [15:0] exp_dr [4];

  always #5 clk = ~clk;

  sik_mem_responder #(.ADDR_W(16), .LAT(2), .STARVE(3)) u0 (.clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr),
    .i_gnt(gi[0]), .i_rvalid(iv[0]), .i_rdata(ir[0]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(gd[0]), .d_rvalid(dv[0]), .d_rdata(dr[0]), .busy(bs[0]));
  sik_mem_responder #(.ADDR_W(8), .LAT(1), .STARVE(3)) u1 (.clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr[7:0]),
    .i_gnt(gi[1]), .i_rvalid(iv[1]), .i_rdata(ir[1]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr[7:0]), .d_wdata(d_wdata),
    .d_gnt(gd[1]), .d_rvalid(dv[1]), .d_rdata(dr[1]), .busy(bs[1]));
  sik_mem_responder #(.ADDR_W(16), .LAT(3), .STARVE(3)) u2 (.clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr),
    .i_gnt(gi[2]), .i_rvalid(iv[2]), .i_rdata(ir[2]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(gd[2]), .d_rvalid(dv[2]), .d_rdata(dr[2]), .busy(bs[2]));
  sik_mem_responder #(.ADDR_W(16), .LAT(4), .STARVE(3)) u3 (.clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr),
    .i_gnt(gi[3]), .i_rvalid(iv[3]), .i_rdata(ir[3]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(gd[3]), .d_rvalid(dv[3]), .d_rdata(dr[3]), .busy(bs[3]));

  task automatic model_reset();
    ent_t e;
    e.v = 0; e.is_i = 0; e.d16 = 0; e.d8 = 0;
    hist.delete();
    for (int k = 0; k < 4; k++) hist.push_back(e);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin exp_ir[k] = 0; exp_dr[k] = 0; end
  endtask

  task automatic check_out();
    ent_t e;
    bit bz, ei, ed;
    for (int k = 0; k < 4; k++) begin
      e = hist[hist.size() - lat_t[k]];
      bz = 0;
      for (int j = 1; j <= lat_t[k]; j++) bz |= hist[hist.size() - j].v;
      ei = e.v && e.is_i;
      ed = e.v && !e.is_i;
      if (ei) exp_ir[k] = (k == 1) ? e.d8 : e.d16;
      if (ed) exp_dr[k] = (k == 1) ? e.d8 : e.d16;
      vec += 5;
      if (iv[k] !== ei) begin err++; $display("FAIL i_rvalid dut%0d t=%0t: got %b want %b", k, $time, iv[k], ei); end
      if (ir[k] !== exp_ir[k]) begin err++; $display("FAIL i_rdata dut%0d t=%0t: got %h want %h", k, $time, ir[k], exp_ir[k]); end
      if (dv[k] !== ed) begin err++; $display("FAIL d_rvalid dut%0d t=%0t: got %b want %b", k, $time, dv[k], ed); end
      if (dr[k] !== exp_dr[k]) begin err++; $display("FAIL d_rdata dut%0d t=%0t: got %h want %h", k, $time, dr[k], exp_dr[k]); end
      if (bs[k] !== bz) begin err++; $display("FAIL busy dut%0d t=%0t: got %b want %b", k, $time, bs[k], bz); end
    end
  endtask

  task automatic cyc(output bit ge_i, output bit ge_d);
    ent_t e;
    logic [15:0] a;
    @(negedge clk);
    ge_i = i_req && (!d_req || cnt == 3);
    ge_d = d_req && !ge_i;
    last_gi = gi[0];
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (gi[k] !== ge_i || gd[k] !== ge_d) begin
        err++;
        $display("FAIL gnt dut%0d t=%0t: got i=%b d=%b want i=%b d=%b", k, $time, gi[k], gd[k], ge_i, ge_d);
      end
    end
    a = ge_i ? i_addr : d_addr;
    e.v = ge_i || (ge_d && !d_we);
    e.is_i = ge_i;
    e.d16 = m16.exists(a) ? m16[a] : 16'h0;
    e.d8 = m8[a[7:0]];
    cnt = (i_req && !ge_i) ? (cnt < 3 ? cnt + 1 : 3) : 0;
    if (ge_d && d_we) begin m16[d_addr] = d_wdata; m8[d_addr[7:0]] = d_wdata; end
    @(posedge clk);
    hist.push_back(e);
    #1;
    check_out();
  endtask

  task automatic idle(input int n);
    bit a, b;
    i_req = 0; d_req = 0;
    for (int j = 0; j < n; j++) cyc(a, b);
  endtask

  task automatic store(input logic [15:0] ad, input logic [15:0] wd);
    bit a, b;
    d_req = 1; d_we = 1; d_addr = ad; d_wdata = wd;
    cyc(a, b);
    d_req = 0; d_we = 0;
  endtask

  task automatic check_quiet(input string nm);
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (iv[k] !== 0 || dv[k] !== 0 || bs[k] !== 0 || ir[k] !== 0 || dr[k] !== 0 || gi[k] !== 0 || gd[k] !== 0) begin
        err++;
        $display("FAIL %s dut%0d: got iv=%b dv=%b busy=%b ir=%h dr=%h gi=%b gd=%b want all 0", nm, k, iv[k], dv[k], bs[k], ir[k], dr[k], gi[k], gd[k]);
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 0;
    i_req = 1; d_req = 1;
    #1 check_quiet("reset_async");
    @(posedge clk); @(posedge clk); #1 check_quiet("reset_hold");
    reset = 1; i_req = 0; d_req = 0;
    model_reset();
    idle(10);
  endtask

  task automatic test_init();
    for (int a = 0; a < 32; a++) store(16'(a), 16'($urandom));
    store(16'h0040, 16'h1234);
    idle(4);
  endtask

  task automatic test_raw();
    bit a, b;
    store(16'h0040, 16'hBEEF);
    i_req = 1; i_addr = 16'h0040;
    cyc(a, b);
    i_req = 0;
    cyc(a, b);
    vec++;
    if (iv[0] !== 1'b1 || ir[0] !== 16'hBEEF || dv[0] !== 1'b0) begin
      err++;
      $display("FAIL raw_fetch: got iv=%b ir=%h dv=%b want iv=1 ir=beef dv=0", iv[0], ir[0], dv[0]);
    end
    idle(4);
  endtask

  task automatic test_starve();
    bit a, b;
    i_req = 1; d_req = 1; d_we = 0;
    i_addr = 16'($urandom_range(31)); d_addr = 16'($urandom_range(31));
    for (int j = 0; j < 16; j++) begin
      cyc(a, b);
      vec++;
      if (last_gi !== ((j % 4) == 3)) begin
        err++;
        $display("FAIL starve_pattern slot %0d: got i_gnt=%b want %b", j, last_gi, (j % 4) == 3);
      end
      if (a) i_addr = 16'($urandom_range(31));
      if (b) d_addr = 16'($urandom_range(31));
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    bit a, b;
    store(16'h0001, 16'h1111);
    store(16'h0002, 16'h2222);
    for (int j = 0; j < 8; j++) begin
      d_req = 1; d_we = 0; d_addr = (j % 2 == 0) ? 16'h0001 : 16'h0002;
      cyc(a, b);
      if (j >= 1) begin
        vec++;
        if (dv[0] !== 1'b1 || dr[0] !== (((j - 1) % 2 == 0) ? 16'h1111 : 16'h2222)) begin
          err++;
          $display("FAIL back_to_back slot %0d: got dv=%b dr=%h", j, dv[0], dr[0]);
        end
      end
    end
    idle(5);
  endtask

  task automatic test_wrap();
    bit a, b;
    store(16'h01FF, 16'h5555);
    store(16'h00FF, 16'h00AA);
    d_req = 1; d_we = 0; d_addr = 16'h01FF;
    cyc(a, b);
    d_req = 0;
    vec++;
    if (dv[1] !== 1'b1 || dr[1] !== 16'h00AA) begin
      err++;
      $display("FAIL addr_wrap: got dv=%b dr=%h want dv=1 dr=00aa", dv[1], dr[1]);
    end
    idle(5);
  endtask

  task automatic test_lat_sweep();
    bit a, b;
    int first [4];
    int nb [4];
    d_req = 1; d_we = 0; d_addr = 16'h0007;
    cyc(a, b);
    d_req = 0;
    for (int k = 0; k < 4; k++) begin first[k] = 0; nb[k] = 0; end
    for (int j = 1; j <= 8; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (dv[k] && first[k] == 0) first[k] = j;
        if (bs[k]) nb[k]++;
      end
      cyc(a, b);
    end
    for (int k = 0; k < 4; k++) begin
      vec += 2;
      if (first[k] != lat_t[k]) begin err++; $display("FAIL lat_distance dut%0d: got %0d want %0d", k, first[k], lat_t[k]); end
      if (nb[k] != lat_t[k]) begin err++; $display("FAIL busy_window dut%0d: got %0d want %0d", k, nb[k], lat_t[k]); end
    end
  endtask

  task automatic test_random();
    bit a, b;
    i_req = 0; d_req = 0;
    for (int j = 0; j < 500; j++) begin
      cyc(a, b);
      if (a || !i_req) begin
        i_req = ($urandom_range(2) != 0);
        i_addr = 16'($urandom_range(31));
      end
      if (b || !d_req) begin
        d_req = ($urandom_range(2) != 0);
        d_we = $urandom_range(1) == 1;
        d_addr = 16'($urandom_range(31));
        d_wdata = 16'($urandom);
      end
    end
    idle(5);
  endtask

  task automatic test_reset_mid();
    bit a, b;
    i_req = 1; i_addr = 16'h0003;
    cyc(a, b);
    i_req = 0; d_req = 1; d_we = 0; d_addr = 16'h0004;
    cyc(a, b);
    d_req = 0;
    #2 reset = 0;
    #1 check_quiet("reset_mid");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    idle(8);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init();
    test_raw();
    test_starve();
    test_back_to_back();
    test_wrap();
    test_lat_sweep();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
